// File: rtl/sci_uart_pkg.sv
// Shared definitions for the MiniS08 SCI/UART peripheral: register offsets,
// STATUS bit positions, FSM state encodings and the divisor floor.
package sci_uart_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_STAT  = 2'd1;
    localparam logic [1:0] ADDR_BAUDL = 2'd2;
    localparam logic [1:0] ADDR_BAUDH = 2'd3;

    localparam int STAT_TDRE = 7;
    localparam int STAT_TC   = 6;
    localparam int STAT_RDRF = 5;
    localparam int STAT_OR   = 3;
    localparam int STAT_FE   = 1;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Divisors below the floor would leave no room for a half-bit start check.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/sci_bitclk.sv
// Bit-period timer: a loadable down-counter producing a one-cycle tick at the
// end of every bit period. Restart loads a full or half period; otherwise the
// counter reloads itself from the live divisor at each tick, so a divisor
// change only lands on a bit boundary.
module sci_bitclk
    import sci_uart_pkg::*;
(
    input  logic        clk50,
    input  logic        reset,
    input  logic [15:0] div,
    input  logic        restart,
    input  logic        half,
    output logic        tick
);

    logic [15:0] div_eff;
    logic [15:0] load;
    logic [15:0] cnt;

    assign div_eff = clamp_div(div);
    assign load    = half ? {1'b0, div_eff[15:1]} : div_eff;

    // Count down one bit period, reloading on restart or when the period expires.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (restart)
            cnt <= load - 16'd1;
        else if (cnt == '0)
            cnt <= div_eff - 16'd1;
        else
            cnt <= cnt - 16'd1;
    end

    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/sci_uart.sv
// MiniS08 SCI/UART: 4-byte register window (DATA, STATUS, BAUDL, BAUDH),
// 8N1 transmitter and receiver sharing one programmable baud divisor.
module sci_uart
    import sci_uart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd5208
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       sel,
    input  logic [1:0] addr,
    input  logic       read,
    input  logic       write,
    input  logic       rxd,
    output logic       txd
);

    logic       wr_q, rd_q;
    logic       wr_pulse, rd_pulse, rd_clear;
    logic [7:0] tdr, rxbuf, baudl, baudh, status;
    logic       tdre, tc, rdrf, ovr, fe;

    tx_state_t  tx_state, tx_next;
    logic [7:0] tx_shift, tx_shift_next;
    logic [2:0] tx_bit, tx_bit_next;
    logic       tx_take, tx_done, tx_restart, tx_tick, txd_next;

    rx_state_t  rx_state, rx_next;
    logic [7:0] rx_shift, rx_shift_next;
    logic [2:0] rx_bit, rx_bit_next;
    logic       rx_s1, rx_s2, rx_s3;
    logic       rx_restart, rx_done, rx_tick;

    assign wr_pulse = sel && write && !wr_q;
    assign rd_pulse = sel && read && !rd_q;
    assign rd_clear = rd_pulse && (addr == ADDR_DATA);

    sci_bitclk u_txclk (
        .clk50   (clk50),
        .reset   (reset),
        .div     ({baudh, baudl}),
        .restart (tx_restart),
        .half    (1'b0),
        .tick    (tx_tick)
    );

    sci_bitclk u_rxclk (
        .clk50   (clk50),
        .reset   (reset),
        .div     ({baudh, baudl}),
        .restart (rx_restart),
        .half    (rx_restart),
        .tick    (rx_tick)
    );

    // Transmitter next state: pull TDR into the shifter and walk start/data/stop bits.
    always_comb begin
        tx_next       = tx_state;
        tx_shift_next = tx_shift;
        tx_bit_next   = tx_bit;
        tx_take       = 1'b0;
        tx_done       = 1'b0;
        tx_restart    = 1'b0;
        txd_next      = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!tdre) begin
                    tx_take       = 1'b1;
                    tx_restart    = 1'b1;
                    tx_shift_next = tdr;
                    tx_bit_next   = 3'd0;
                    tx_next       = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick)
                    tx_next = TX_DATA;
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_shift_next = {1'b1, tx_shift[7:1]};
                    tx_bit_next   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7)
                        tx_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (!tdre) begin
                        tx_take       = 1'b1;
                        tx_shift_next = tdr;
                        tx_bit_next   = 3'd0;
                        tx_next       = TX_START;
                    end else begin
                        tx_done = 1'b1;
                        tx_next = TX_IDLE;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
        case (tx_next)
            TX_START: txd_next = 1'b0;
            TX_DATA:  txd_next = tx_shift_next[0];
            default:  txd_next = 1'b1;
        endcase
    end

    // Transmitter state and a registered txd so the pin never glitches.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_bit   <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_next;
            tx_shift <= tx_shift_next;
            tx_bit   <= tx_bit_next;
            txd      <= txd_next;
        end
    end

    // Two-flop synchronizer on rxd plus one more flop to see falling edges.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // Receiver next state: half-bit start check, then sample mid-bit each period.
    always_comb begin
        rx_next       = rx_state;
        rx_shift_next = rx_shift;
        rx_bit_next   = rx_bit;
        rx_restart    = 1'b0;
        rx_done       = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_s3 && !rx_s2) begin
                    rx_restart = 1'b1;
                    rx_next    = RX_START;
                end
            end
            RX_START: begin
                rx_bit_next = 3'd0;
                if (rx_tick)
                    rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_next = {rx_s2, rx_shift[7:1]};
                    rx_bit_next   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7)
                        rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_done = 1'b1;
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Receiver state register; reset discards any partially assembled byte.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_next;
            rx_shift <= rx_shift_next;
            rx_bit   <= rx_bit_next;
        end
    end

    // Register file: one action per CPU strobe edge; frame completion beats a same-cycle read-clear.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            tdr   <= '0;
            tdre  <= 1'b1;
            tc    <= 1'b1;
            rxbuf <= '0;
            rdrf  <= 1'b0;
            ovr   <= 1'b0;
            fe    <= 1'b0;
            baudl <= DIV_RESET[7:0];
            baudh <= DIV_RESET[15:8];
        end else begin
            wr_q <= sel && write;
            rd_q <= sel && read;
            if (wr_pulse) begin
                case (addr)
                    ADDR_DATA: begin
                        if (tdre) begin
                            tdr  <= din;
                            tdre <= 1'b0;
                        end
                    end
                    ADDR_BAUDL: baudl <= din;
                    ADDR_BAUDH: baudh <= din;
                    default: ;
                endcase
            end
            if (tx_take) begin
                tdre <= 1'b1;
                tc   <= 1'b0;
            end
            if (tx_done)
                tc <= 1'b1;
            if (rd_clear) begin
                rdrf <= 1'b0;
                ovr  <= 1'b0;
                fe   <= 1'b0;
            end
            if (rx_done) begin
                if (!rdrf || rd_clear) begin
                    rxbuf <= rx_shift;
                    rdrf  <= 1'b1;
                    fe    <= !rx_s2;
                end else begin
                    ovr <= 1'b1;
                end
            end
        end
    end

    // STATUS image and the combinational read mux, zero unless selected for read.
    always_comb begin
        status            = '0;
        status[STAT_TDRE] = tdre;
        status[STAT_TC]   = tc;
        status[STAT_RDRF] = rdrf;
        status[STAT_OR]   = ovr;
        status[STAT_FE]   = fe;
        dout              = '0;
        if (sel && read) begin
            case (addr)
                ADDR_DATA:  dout = rxbuf;
                ADDR_STAT:  dout = status;
                ADDR_BAUDL: dout = baudl;
                ADDR_BAUDH: dout = baudh;
                default:    dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sci_uart.sv
// Testbench for sci_uart: directed and randomized TX/RX traffic checked
// against a frame-level model of the serial line and the receive flags.
module tb_sci_uart;
    import sci_uart_pkg::*;

    logic       clk50 = 1'b0;
    logic       reset;
    logic [7:0] din, dout;
    logic       sel, read, write, rxd, txd;
    logic [1:0] addr;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   fall_cyc = -1;
    logic txd_prev = 1'b1;

    logic [7:0] m_buf;
    logic       m_rdrf, m_or, m_fe;
    int         div_eff;

    sci_uart #(.DIV_RESET(16'd5208)) dut (
        .clk50 (clk50),
        .reset (reset),
        .din   (din),
        .dout  (dout),
        .sel   (sel),
        .addr  (addr),
        .read  (read),
        .write (write),
        .rxd   (rxd),
        .txd   (txd)
    );

    always #10 clk50 = ~clk50;

    initial begin
        #4_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepClk();
        @(negedge clk50);
        cyc++;
        if (txd_prev === 1'b1 && txd === 1'b0)
            fall_cyc = cyc;
        txd_prev = txd;
    endtask

    task automatic idle(input int n);
        repeat (n) stepClk();
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
        sel = 1'b1; write = 1'b1; addr = a; din = d;
        idle(4);
        sel = 1'b0; write = 1'b0; din = 8'h00;
        idle(1);
    endtask

    task automatic readReg(input logic [1:0] a, output logic [7:0] d);
        sel = 1'b1; read = 1'b1; addr = a;
        idle(1);
        d = dout;
        idle(3);
        sel = 1'b0; read = 1'b0;
        idle(1);
    endtask

    task automatic checkReg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        readReg(a, d);
        checkOutput(tag, d, exp);
    endtask

    function automatic logic [7:0] modelStatus();
        return {1'b1, 1'b1, m_rdrf, 1'b0, m_or, 1'b0, m_fe, 1'b0};
    endfunction

    task automatic modelRxFrame(input logic [7:0] b, input logic stopb);
        if (!m_rdrf) begin
            m_buf  = b;
            m_rdrf = 1'b1;
            m_fe   = !stopb;
        end else begin
            m_or = 1'b1;
        end
    endtask

    task automatic checkDataRead(input string tag);
        checkReg(tag, ADDR_DATA, m_buf);
        m_rdrf = 1'b0; m_or = 1'b0; m_fe = 1'b0;
    endtask

    task automatic setDiv(input int d);
        logic [15:0] v;
        v = d[15:0];
        applyStimulus(ADDR_BAUDL, v[7:0]);
        applyStimulus(ADDR_BAUDH, v[15:8]);
        div_eff = (d < 4) ? 4 : d;
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopb);
        rxd = 1'b0;
        idle(div_eff);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(div_eff);
        end
        rxd = stopb;
        idle(div_eff);
        rxd = 1'b1;
        idle(8);
        modelRxFrame(b, stopb);
    endtask

    task automatic waitFall(input string tag, output int t0);
        int k;
        k = 0;
        while (fall_cyc < 0 && k < 200) begin
            stepClk();
            k++;
        end
        n_cmp++;
        assert (fall_cyc >= 0)
        else begin
            n_bad++;
            $error("[TB] FAIL %s: observed no start bit expected one within 200 cycles", tag);
        end
        t0 = (fall_cyc >= 0) ? fall_cyc : cyc;
    endtask

    task automatic checkTxStream(input string tag, input int t0, input logic [7:0] b0,
                                 input logic [7:0] b1, input int nframes, input int tail);
        logic       bits[$];
        logic [7:0] b;
        logic       exp;
        int         total, idx;
        for (int f = 0; f < nframes; f++) begin
            b = (f == 0) ? b0 : b1;
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                bits.push_back(b[i]);
            bits.push_back(1'b1);
        end
        total = bits.size() * div_eff;
        while (cyc - t0 < total + tail) begin
            stepClk();
            idx = cyc - t0;
            exp = (idx < total) ? bits[idx / div_eff] : 1'b1;
            checkOutput(tag, {7'b0, txd}, {7'b0, exp});
        end
    endtask

    initial begin
        int         t0;
        logic [7:0] b, rd;
        logic       stopb;
        int         d;

        reset = 1'b1; sel = 1'b0; read = 1'b0; write = 1'b0;
        din = 8'h00; addr = 2'd0; rxd = 1'b1;
        m_buf = 8'h00; m_rdrf = 1'b0; m_or = 1'b0; m_fe = 1'b0;
        div_eff = 5208;
        idle(3);
        reset = 1'b0;
        idle(2);

        $display("[TB] reset values");
        checkOutput("reset_txd", {7'b0, txd}, 8'h01);
        read = 1'b1; addr = ADDR_STAT;
        idle(1);
        checkOutput("unselected_dout", dout, 8'h00);
        read = 1'b0;
        idle(1);
        checkReg("reset_status", ADDR_STAT, 8'hC0);
        checkReg("reset_baudl", ADDR_BAUDL, 8'h58);
        checkReg("reset_baudh", ADDR_BAUDH, 8'h14);
        checkReg("reset_rxbuf", ADDR_DATA, 8'h00);

        setDiv(16);
        checkReg("baudl_16", ADDR_BAUDL, 8'h10);
        checkReg("baudh_16", ADDR_BAUDH, 8'h00);

        $display("[TB] transmit 0xA5");
        fall_cyc = -1;
        applyStimulus(ADDR_DATA, 8'hA5);
        waitFall("tx_a5_start", t0);
        checkReg("tx_status_in_start", ADDR_STAT, 8'h80);
        checkTxStream("tx_a5_bits", t0, 8'hA5, 8'h00, 1, 8);
        checkReg("tx_status_done", ADDR_STAT, 8'hC0);

        b = 8'($urandom);
        fall_cyc = -1;
        applyStimulus(ADDR_DATA, b);
        waitFall("tx_rand_start", t0);
        checkTxStream("tx_rand_bits", t0, b, 8'h00, 1, 8);

        $display("[TB] back-to-back transmit with a dropped third write");
        fall_cyc = -1;
        applyStimulus(ADDR_DATA, 8'h55);
        waitFall("tx_b2b_start", t0);
        applyStimulus(ADDR_DATA, 8'hAA);
        applyStimulus(ADDR_DATA, 8'h0F);
        checkTxStream("tx_b2b_bits", t0, 8'h55, 8'hAA, 2, 48);
        checkReg("tx_b2b_status", ADDR_STAT, 8'hC0);

        $display("[TB] receive frames");
        sendFrame(8'h3C, 1'b1);
        checkReg("rx_3c_status", ADDR_STAT, modelStatus());
        checkDataRead("rx_3c_data");
        checkReg("rx_3c_cleared", ADDR_STAT, modelStatus());

        sendFrame(8'h11, 1'b1);
        sendFrame(8'h22, 1'b1);
        checkReg("rx_overrun_status", ADDR_STAT, modelStatus());
        checkDataRead("rx_overrun_data");
        checkReg("rx_overrun_cleared", ADDR_STAT, modelStatus());

        b = 8'($urandom);
        sendFrame(b, 1'b0);
        checkReg("rx_fe_status", ADDR_STAT, modelStatus());
        checkDataRead("rx_fe_data");

        rxd = 1'b0;
        idle(6);
        rxd = 1'b1;
        idle(48);
        checkReg("rx_glitch_status", ADDR_STAT, modelStatus());

        rxd = 1'b0;
        idle(12 * div_eff);
        rxd = 1'b1;
        idle(8);
        modelRxFrame(8'h00, 1'b0);
        checkReg("rx_break_status", ADDR_STAT, modelStatus());
        checkDataRead("rx_break_data");

        $display("[TB] randomized divisor and traffic");
        for (int it = 0; it < 6; it++) begin
            d = int'($urandom_range(0, 24));
            setDiv(d);
            checkReg("rand_baudl", ADDR_BAUDL, 8'(d));
            b = 8'($urandom);
            fall_cyc = -1;
            applyStimulus(ADDR_DATA, b);
            waitFall("rand_tx_start", t0);
            checkTxStream("rand_tx_bits", t0, b, 8'h00, 1, 8);
            b = 8'($urandom);
            stopb = ($urandom_range(0, 3) != 0);
            sendFrame(b, stopb);
            checkReg("rand_rx_status", ADDR_STAT, modelStatus());
            if ($urandom_range(0, 1) == 1) begin
                checkDataRead("rand_rx_data");
                checkReg("rand_rx_cleared", ADDR_STAT, modelStatus());
            end
        end

        $display("[TB] reset in the middle of a frame");
        setDiv(16);
        if (m_rdrf)
            checkDataRead("pre_reset_data");
        fall_cyc = -1;
        applyStimulus(ADDR_DATA, 8'h00);
        waitFall("reset_tx_start", t0);
        idle(40);
        rxd = 1'b0;
        idle(40);
        checkOutput("pre_reset_txd", {7'b0, txd}, 8'h00);
        #2 reset = 1'b1;
        #1 checkOutput("async_reset_txd", {7'b0, txd}, 8'h01);
        idle(2);
        reset = 1'b0;
        rxd = 1'b1;
        m_rdrf = 1'b0; m_or = 1'b0; m_fe = 1'b0; m_buf = 8'h00;
        div_eff = 5208;
        idle(10);
        checkOutput("post_reset_txd", {7'b0, txd}, 8'h01);
        checkReg("post_reset_status", ADDR_STAT, modelStatus());
        checkReg("post_reset_baudl", ADDR_BAUDL, 8'h58);
        checkReg("post_reset_baudh", ADDR_BAUDH, 8'h14);
        checkReg("post_reset_rxbuf", ADDR_DATA, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
